// File: rtl/z16_dmem_arbiter.sv
// z16_dmem_arbiter: two-port arbiter in front of the single-port Z16 data memory.
// Port 0 is the CPU load/store path and port 1 is the loader/debug path.
// The current owner keeps the memory while it keeps requesting, but only for
// MAX_BURST grants in a row if the other port is also waiting. This stops
// either port from starving the other.
// Read data comes back registered one cycle after the grant, on the port that
// was granted.
module z16_dmem_arbiter #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_m0_req,
    input  logic              i_m0_wen,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_gnt,
    output logic              o_m0_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_wen,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wen,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_m0_stall
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              m0_rvalid_q, m0_rvalid_d;
    logic              m1_rvalid_q, m1_rvalid_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              gnt0_raw, gnt1_raw;
    logic              gnt0, gnt1;

    // Grant decision and next owner/burst count, from state, count and requests.
    always_comb begin
        gnt0_raw = 1'b0;
        gnt1_raw = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_m0_req) begin
                    gnt0_raw = 1'b1;
                    state_d  = ST_OWN0;
                    cnt_d    = 4'd1;
                end else if (i_m1_req) begin
                    gnt1_raw = 1'b1;
                    state_d  = ST_OWN1;
                    cnt_d    = 4'd1;
                end
            end
            ST_OWN0: begin
                if (i_m0_req && ((cnt_q < BURST_MAX) || !i_m1_req)) begin
                    gnt0_raw = 1'b1;
                    cnt_d    = (cnt_q >= BURST_MAX) ? BURST_MAX : cnt_q + 4'd1;
                end else if (i_m1_req) begin
                    gnt1_raw = 1'b1;
                    state_d  = ST_OWN1;
                    cnt_d    = 4'd1;
                end else begin
                    state_d  = ST_IDLE;
                    cnt_d    = 4'd0;
                end
            end
            ST_OWN1: begin
                if (i_m1_req && ((cnt_q < BURST_MAX) || !i_m0_req)) begin
                    gnt1_raw = 1'b1;
                    cnt_d    = (cnt_q >= BURST_MAX) ? BURST_MAX : cnt_q + 4'd1;
                end else if (i_m0_req) begin
                    gnt0_raw = 1'b1;
                    state_d  = ST_OWN0;
                    cnt_d    = 4'd1;
                end else begin
                    state_d  = ST_IDLE;
                    cnt_d    = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Grants are forced low while reset is held so the memory sees no access.
    always_comb begin
        gnt0 = gnt0_raw & i_rst_n;
        gnt1 = gnt1_raw & i_rst_n;
    end

    // Memory-side mux: drive the winner's access, or all zero when idle.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wen   = 1'b0;
        o_mem_wdata = '0;
        if (gnt0) begin
            o_mem_addr  = i_m0_addr;
            o_mem_wen   = i_m0_wen;
            o_mem_wdata = i_m0_wdata;
        end else if (gnt1) begin
            o_mem_addr  = i_m1_addr;
            o_mem_wen   = i_m1_wen;
            o_mem_wdata = i_m1_wdata;
        end
    end

    // Read return: capture memory data for the port that was granted a read.
    always_comb begin
        m0_rvalid_d = gnt0 & ~i_m0_wen;
        m1_rvalid_d = gnt1 & ~i_m1_wen;
        m0_rdata_d  = m0_rvalid_d ? i_mem_rdata : m0_rdata_q;
        m1_rdata_d  = m1_rvalid_d ? i_mem_rdata : m1_rdata_q;
    end

    // State, burst count and read-return registers; reset drops any read in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    // Output assignments.
    always_comb begin
        o_m0_gnt    = gnt0;
        o_m1_gnt    = gnt1;
        o_m0_rvalid = m0_rvalid_q;
        o_m1_rvalid = m1_rvalid_q;
        o_m0_rdata  = m0_rdata_q;
        o_m1_rdata  = m1_rdata_q;
        o_m0_stall  = i_m0_req & ~gnt0;
    end

endmodule

// File: tb/tb_z16_dmem_arbiter.sv
// tb_z16_dmem_arbiter: directed scenarios plus randomized traffic for the
// Z16 data memory arbiter. A behavioural model tracks the owner, the length
// of its current run, a reference memory image and the expected read
// returns. The DUT is compared against that model on every cycle.
module tb_z16_dmem_arbiter;

    localparam int MAXB = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_m0_req = 1'b0, i_m0_wen = 1'b0;
    logic [15:0] i_m0_addr = '0, i_m0_wdata = '0;
    logic        i_m1_req = 1'b0, i_m1_wen = 1'b0;
    logic [15:0] i_m1_addr = '0, i_m1_wdata = '0;
    logic        o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid;
    logic [15:0] o_m0_rdata, o_m1_rdata;
    logic [15:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic        o_mem_wen, o_m0_stall;

    int checks = 0;
    int errors = 0;

    // memory device (environment) and the model's reference image
    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];

    // behavioural model state
    int          own;      // -1 = nobody owns the memory
    int          run;      // consecutive grants given to the owner
    int          exp_g;    // expected grant this cycle: -1, 0 or 1
    logic        exp_rv [2];
    logic [15:0] exp_rd [2];

    z16_dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .MAX_BURST(MAXB)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_m0_req(i_m0_req), .i_m0_wen(i_m0_wen), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
        .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
        .i_m1_req(i_m1_req), .i_m1_wen(i_m1_wen), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
        .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .o_m0_stall(o_m0_stall)
    );

    always #5 i_clk = ~i_clk;

    assign i_mem_rdata = mem[o_mem_addr[7:0]];

    always @(posedge i_clk) begin
        if (o_mem_wen) mem[o_mem_addr[7:0]] <= o_mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        own = -1;
        run = 0;
        exp_g = -1;
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
        exp_rd[0] = '0;   exp_rd[1] = '0;
    endtask

    // Decide who must win this cycle and compare every DUT output.
    task automatic compare();
        logic        rq [2];
        logic [15:0] ea, ed;
        logic        ew;
        int          other;
        rq[0] = i_m0_req;
        rq[1] = i_m1_req;
        exp_g = -1;
        if (i_rst_n) begin
            if (own < 0) begin
                if (rq[0]) exp_g = 0;
                else if (rq[1]) exp_g = 1;
            end else begin
                other = 1 - own;
                if (rq[own] && (run < MAXB || !rq[other])) exp_g = own;
                else if (rq[other]) exp_g = other;
            end
        end
        ea = (exp_g == 0) ? i_m0_addr  : (exp_g == 1) ? i_m1_addr  : 16'h0;
        ed = (exp_g == 0) ? i_m0_wdata : (exp_g == 1) ? i_m1_wdata : 16'h0;
        ew = (exp_g == 0) ? i_m0_wen   : (exp_g == 1) ? i_m1_wen   : 1'b0;
        check("m0_gnt",    32'(o_m0_gnt),    32'(exp_g == 0));
        check("m1_gnt",    32'(o_m1_gnt),    32'(exp_g == 1));
        check("m0_stall",  32'(o_m0_stall),  32'(i_m0_req && exp_g != 0));
        check("mem_addr",  32'(o_mem_addr),  32'(ea));
        check("mem_wdata", 32'(o_mem_wdata), 32'(ed));
        check("mem_wen",   32'(o_mem_wen),   32'(ew));
        check("m0_rvalid", 32'(o_m0_rvalid), 32'(exp_rv[0]));
        check("m1_rvalid", 32'(o_m1_rvalid), 32'(exp_rv[1]));
        check("m0_rdata",  32'(o_m0_rdata),  32'(exp_rd[0]));
        check("m1_rdata",  32'(o_m1_rdata),  32'(exp_rd[1]));
    endtask

    // Advance the model across a rising edge using its own grant decision.
    task automatic model_edge();
        logic        w;
        logic [15:0] a, d;
        if (!i_rst_n) return;
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        if (exp_g >= 0) begin
            w = (exp_g == 0) ? i_m0_wen   : i_m1_wen;
            a = (exp_g == 0) ? i_m0_addr  : i_m1_addr;
            d = (exp_g == 0) ? i_m0_wdata : i_m1_wdata;
            if (w) ref_mem[a[7:0]] = d;
            else begin
                exp_rv[exp_g] = 1'b1;
                exp_rd[exp_g] = ref_mem[a[7:0]];
            end
            if (exp_g == own) run = (run + 1 > MAXB) ? MAXB : run + 1;
            else begin
                own = exp_g;
                run = 1;
            end
        end else begin
            own = -1;
            run = 0;
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                                 input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1);
        @(negedge i_clk);
        i_m0_req = r0; i_m0_wen = w0; i_m0_addr = a0; i_m0_wdata = d0;
        i_m1_req = r1; i_m1_wen = w1; i_m1_addr = a1; i_m1_wdata = d1;
        #1;
        compare();
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_edge();
    endtask

    task automatic idle_cycle();
        applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        tick();
    endtask

    logic        p0, pw0, p1, pw1;
    logic [15:0] pa0, pd0, pa1, pd1;
    int          seq [10];
    int          g;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        model_reset();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // reset while an m0 read at 0x0010 is being granted
        applyStimulus(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
        check("rst_read_gnt", 32'(o_m0_gnt), 32'd1);
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_gnt_low", 32'(o_m0_gnt), 32'd0);
        check("rst_addr_low", 32'(o_mem_addr), 32'd0);
        tick();
        #1;
        check("rst_no_rvalid", 32'(o_m0_rvalid), 32'd0);
        applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        i_rst_n = 1'b1;
        tick();
        idle_cycle();
        check("rst_after_rvalid", 32'(o_m0_rvalid), 32'd0);
        check("rst_after_rdata", 32'(o_m0_rdata), 32'd0);

        // tie from idle then burst alternation, both ports hold requests
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 16'h0031, 16'h0, 1, 0, 16'h0042, 16'h0);
            seq[i] = o_m0_gnt ? 0 : (o_m1_gnt ? 1 : -1);
            if (i == 0) begin
                check("tie_m1_gnt", 32'(o_m1_gnt), 32'd0);
                check("tie_stall", 32'(o_m0_stall), 32'd0);
                check("tie_addr", 32'(o_mem_addr), 32'h0031);
            end
            check("burst_stall", 32'(o_m0_stall), 32'(i >= 4 && i < 8));
            tick();
        end
        for (int i = 0; i < 10; i++)
            check("burst_seq", 32'(seq[i]), (i >= 4 && i < 8) ? 32'd1 : 32'd0);
        idle_cycle();
        idle_cycle();

        // m1 writes 0xBEEF to 0x0020 then reads it back
        applyStimulus(0, 0, 16'h0, 16'h0, 1, 1, 16'h0020, 16'hBEEF);
        check("wr_mem_wen", 32'(o_mem_wen), 32'd1);
        tick();
        applyStimulus(0, 0, 16'h0, 16'h0, 1, 0, 16'h0020, 16'h0);
        check("rd_gnt", 32'(o_m1_gnt), 32'd1);
        check("rd_no_early_rvalid", 32'(o_m1_rvalid), 32'd0);
        tick();
        applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        check("rd_rvalid", 32'(o_m1_rvalid), 32'd1);
        check("rd_rdata", 32'(o_m1_rdata), 32'hBEEF);
        check("rd_m0_quiet", 32'(o_m0_rvalid), 32'd0);
        tick();
        idle_cycle();

        // owner release after two grants, then m1 is served at once
        applyStimulus(1, 0, 16'h0005, 16'h0, 0, 0, 16'h0, 16'h0);
        tick();
        applyStimulus(1, 0, 16'h0006, 16'h0, 0, 0, 16'h0, 16'h0);
        tick();
        applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        check("rel_wen", 32'(o_mem_wen), 32'd0);
        check("rel_addr", 32'(o_mem_addr), 32'd0);
        tick();
        applyStimulus(0, 0, 16'h0, 16'h0, 1, 0, 16'h0077, 16'h0);
        check("rel_m1_gnt", 32'(o_m1_gnt), 32'd1);
        tick();
        idle_cycle();

        // lone m0 for 10 cycles, then contention must hand over immediately
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, i[0], 16'(i + 16'h0050), 16'(i), 0, 0, 16'h0, 16'h0);
            check("solo_gnt", 32'(o_m0_gnt), 32'd1);
            check("solo_stall", 32'(o_m0_stall), 32'd0);
            tick();
        end
        applyStimulus(1, 0, 16'h0060, 16'h0, 1, 0, 16'h0061, 16'h0);
        check("sat_handover", 32'(o_m1_gnt), 32'd1);
        tick();
        idle_cycle();

        // randomized traffic; requesters hold their request until granted
        p0 = 1'b0; p1 = 1'b0;
        pw0 = 1'b0; pw1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1'b1; pw0 = 1'($urandom); pa0 = 16'($urandom_range(0, 255)); pd0 = 16'($urandom);
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1'b1; pw1 = 1'($urandom); pa1 = 16'($urandom_range(0, 255)); pd1 = 16'($urandom);
            end
            applyStimulus(p0, pw0, pa0, pd0, p1, pw1, pa1, pd1);
            g = exp_g;
            tick();
            if (g == 0) p0 = 1'b0;
            if (g == 1) p1 = 1'b0;
        end
        idle_cycle();
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z16_dmem_arbiter.md
Name: z16_dmem_arbiter

Overview:
Two-requester arbiter for the single-port Z16 data memory. Port 0 is the CPU load/store path; port 1 is the loader/debug path.
Uses sticky ownership with a burst limit, so one requester cannot starve the other. Sits between the requesters and the data memory and drives its address, write-enable and write-data lines.
Read data returns one cycle after the grant, tagged per port.

Parameters:
DATA_W, 16, data width of memory words
ADDR_W, 16, memory address width
MAX_BURST, 4, maximum consecutive grants to one owner while the other port is requesting (legal range 1..15)

Ports:
i_clk  input  1  clock; all state updates on the rising edge
i_rst_n  input  1  asynchronous, active-low reset
i_m0_req  input  1  port 0 access request
i_m0_wen  input  1  port 0 access is a write
i_m0_addr  input  ADDR_W  port 0 address
i_m0_wdata  input  DATA_W  port 0 write data
o_m0_gnt  output  1  port 0 access accepted this cycle (combinational)
o_m0_rvalid  output  1  port 0 read data valid (registered)
o_m0_rdata  output  DATA_W  port 0 read data (registered)
i_m1_req, i_m1_wen, i_m1_addr, i_m1_wdata, o_m1_gnt, o_m1_rvalid, o_m1_rdata  same as port 0, for port 1
o_mem_addr  output  ADDR_W  address to data memory
o_mem_wen  output  1  write enable to data memory
o_mem_wdata  output  DATA_W  write data to data memory
i_mem_rdata  input  DATA_W  combinational read data from data memory
o_m0_stall  output  1  i_m0_req & ~o_m0_gnt; CPU holds its PC on this

Behaviour:
- Reset (i_rst_n low, async):
  - state=IDLE, burst count=0, both rvalid=0, both rdata=0.
  - Grants and memory outputs read 0 while reset is asserted.
  - An in-flight read is dropped; no rvalid is issued after reset releases.
- State machine: IDLE, OWN0, OWN1. The grant decision is combinational from state, count and requests. State and count update on the clock edge.
- IDLE:
  - m0_req: grant 0, next OWN0, cnt=1.
  - else m1_req: grant 1, next OWN1, cnt=1.
  - else no grant, stay IDLE.
- OWNx (other port y):
  - req_x and (cnt<MAX_BURST or !req_y): grant x, cnt=min(cnt+1, MAX_BURST).
  - else req_y: grant y, next OWNy, cnt=1.
  - else no grant, next IDLE, cnt=0.
- At most one gnt high per cycle. A requester holds req, addr, wen and wdata stable until it sees gnt. A request that is not granted causes no side effect.
- Memory-side outputs:
  - When granted: they mirror the granted port's addr, wdata, and wen.
  - When nothing is granted: all zero.
  - A write commits at the clock edge ending the grant cycle.
- Reads:
  - A granted read (wen=0) captures i_mem_rdata into that port's rdata at the edge.
  - That port's rvalid is high for exactly the next cycle. Latency is 1 cycle from gnt to rvalid.
  - rdata holds its last value when rvalid is low.
  - The other port's rvalid and rdata are unaffected.
- Granted writes produce no rvalid.
- Back-to-back reads on consecutive grants produce rvalid on consecutive cycles.
- MAX_BURST=1 degenerates to strict alternation under contention.
- The counter saturates at MAX_BURST and never wraps.
- Counter width is 4 bits.

Test Plan:
- Reset mid-read: m0 read granted at addr 0x0010, i_rst_n low before the next edge. Required: o_m0_rvalid never asserts; after release state=IDLE and all outputs 0.
- Idle tie: both req high from IDLE. Required: o_m0_gnt=1 first cycle, o_m1_gnt=0, o_m0_stall=0, o_mem_addr=i_m0_addr.
- Burst limit: MAX_BURST=4, both req held high continuously. Required grant sequence 0,0,0,0,1,1,1,1,0...; o_m0_stall high exactly during the 4 port-1 cycles.
- Read latency: m1 writes 0xBEEF to 0x0020, then m1 reads 0x0020. Required: o_mem_wen=1 on the write cycle; o_m1_rvalid=1 with o_m1_rdata=0xBEEF exactly one cycle after the read gnt; o_m0_rvalid stays 0.
- Owner release: OWN0 with cnt=2; m0 drops req and m1 has no req. Required: next state IDLE, o_mem_wen=0, o_mem_addr=0. A later m1 req is granted immediately.
- Single requester beyond limit: only m0 requests for 10 cycles. Required: granted every cycle, counter saturated at 4, no stall.
